// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Latency: n/a (constants, types and a pure decode helper).
// Backpressure: n/a.
package muldiv_pkg;

    // M-extension ALU control codes handled by the sequential unit
    localparam logic [4:0] OP_DIVU   = 5'd11;
    localparam logic [4:0] OP_DIV    = 5'd12;
    localparam logic [4:0] OP_REMU   = 5'd13;
    localparam logic [4:0] OP_REM    = 5'd14;
    localparam logic [4:0] OP_MUL    = 5'd15;
    localparam logic [4:0] OP_MULHU  = 5'd16;
    localparam logic [4:0] OP_MULHSU = 5'd17;
    localparam logic [4:0] OP_MULH   = 5'd18;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } state_t;

    function automatic logic is_muldiv_op(input logic [4:0] alu_ctl);
        return (alu_ctl >= OP_DIVU) && (alu_ctl <= OP_MULH);
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit (one result bit per cycle, shared 64-bit shift register).
// Latency: done 35 cycles after accepted start (2 on the divide-by-zero / overflow fast paths).
// Backpressure: none; caller stalls while busy is high, starts outside IDLE are dropped.
//
// Ports: clk, rst_n (async, active low); start/alu_ctl/a/b launch an op;
// flush aborts an op in flight; busy, done (1-cycle pulse), result (held).
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [4:0]      alu_ctl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    logic [4:0]        op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   opb;      // multiplicand (mul) or divisor (div)
    logic [2*XLEN-1:0] acc;      // {hi, lo}: product, or {remainder, dividend/quotient}
    logic [4:0]        count;
    logic              neg_q;    // product / quotient sign
    logic              neg_r;    // remainder sign

    logic              a_sgn;
    logic              b_sgn;
    logic              is_div;
    logic              is_rem;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_part;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_val;

    always_comb begin
        a_sgn    = (op_q == OP_DIV) || (op_q == OP_REM) || (op_q == OP_MULH) || (op_q == OP_MULHSU);
        b_sgn    = (op_q == OP_DIV) || (op_q == OP_REM) || (op_q == OP_MULH);
        is_div   = (op_q <= OP_REM);
        is_rem   = (op_q == OP_REMU) || (op_q == OP_REM);
        mag_a    = (a_sgn && a_q[XLEN-1]) ? -a_q : a_q;
        mag_b    = (b_sgn && b_q[XLEN-1]) ? -b_q : b_q;

        // Multiply: conditionally add multiplicand into the high half, then shift right.
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});

        // Divide: shift left, trial-subtract the divisor from the 33-bit partial remainder.
        // When the trial succeeds the difference is below the divisor, so 32 bits suffice.
        div_part = acc[2*XLEN-1:XLEN-1];
        div_ge   = (div_part >= {1'b0, opb});
        div_diff = acc[2*XLEN-2:XLEN-1] - opb;

        if (is_div) begin
            step = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};
        end else begin
            step = {mul_sum, acc[XLEN-1:1]};
        end

        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

        fix_val = prod[2*XLEN-1:XLEN];
        if (op_q == OP_MUL) begin
            fix_val = prod[XLEN-1:0];
        end else if (is_rem) begin
            fix_val = rem;
        end else if (is_div) begin
            fix_val = quo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            opb    <= '0;
            acc    <= '0;
            count  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush && is_muldiv_op(alu_ctl)) begin
                        op_q  <= alu_ctl;
                        a_q   <= a;
                        b_q   <= b;
                        busy  <= 1'b1;
                        state <= PREP;
                    end
                end
                PREP: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        neg_q <= (a_sgn & a_q[XLEN-1]) ^ (b_sgn & b_q[XLEN-1]);
                        neg_r <= a_sgn & a_q[XLEN-1];
                        if (is_div && (b_q == '0)) begin
                            result <= is_rem ? a_q : '1;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= DONE;
                        end else if (is_div && a_sgn && (a_q == SMIN) && (b_q == '1)) begin
                            result <= is_rem ? '0 : SMIN;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= DONE;
                        end else begin
                            // Divide iterates over the dividend, multiply over the multiplier.
                            acc   <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                            opb   <= is_div ? mag_b : mag_a;
                            count <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc   <= step;
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        result <= fix_val;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
